bsg_fifo_1r1w_small_width_p10_els_p4: RTL and testbench

Four-entry, 10-bit valid/ready FIFO that sits directly upstream of the 10-bit enable-gated reset register stage. It absorbs bursts from a ready/valid producer and presents a registered head word with a valid/yumi consumer handshake. Its storage entries are the team's 10-bit synchronous-reset, enable-gated registers. Its dequeue strobe is what drives the downstream register's enable.

---
 rtl/bsg_fifo_1r1w_small_width_p10_els_p4_pkg.sv | 14 +
 rtl/bsg_fifo_1r1w_small_width_p10_els_p4_reg.sv | 22 ++
 rtl/bsg_fifo_1r1w_small_width_p10_els_p4.sv | 67 ++++++
 tb/tb_bsg_fifo_1r1w_small_width_p10_els_p4.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/bsg_fifo_1r1w_small_width_p10_els_p4_pkg.sv
// Shared constants and a width helper for the 4-entry, 10-bit small FIFO.
package bsg_fifo_1r1w_small_width_p10_els_p4_pkg;

  localparam int default_width_lp = 10;
  localparam int default_els_lp   = 4;

  // Never returns 0, so a 1-entry build still gets a 1-bit pointer.
  function automatic int safe_clog2(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small_width_p10_els_p4_reg.sv
// Synchronous-reset, enable-gated storage register; reset only lands when en_i is high.
module bsg_fifo_1r1w_small_width_p10_els_p4_reg #(
  parameter int width_p = 10
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] data_reg;

  always_ff @(posedge clock_i) begin
    if (en_i) begin
      data_reg <= reset_i ? '0 : data_i;
    end
  end

  assign data_o = data_reg;

endmodule

// File: rtl/bsg_fifo_1r1w_small_width_p10_els_p4.sv
// Four-entry valid/ready in, valid/yumi out FIFO with registered head word and no bypass.
module bsg_fifo_1r1w_small_width_p10_els_p4
  import bsg_fifo_1r1w_small_width_p10_els_p4_pkg::*;
#(
  parameter int width_p = default_width_lp,
  parameter int els_p   = default_els_lp
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp   = safe_clog2(els_p);
  localparam int count_w_lp = ptr_w_lp + 1;

  logic [ptr_w_lp-1:0]   wptr_reg;
  logic [ptr_w_lp-1:0]   rptr_reg;
  logic [count_w_lp-1:0] count_reg;

  logic full, empty, enq, deq;
  logic [width_p-1:0] entry_data [els_p];

  assign full    = (count_reg == count_w_lp'(els_p));
  assign empty   = (count_reg == '0);
  assign ready_o = ~full & ~reset_i;
  assign v_o     = ~empty;

  // ready_o already masks reset; deq is killed explicitly so reset wins.
  assign enq = v_i & ready_o;
  assign deq = yumi_i & v_o & ~reset_i;

  for (genvar gi = 0; gi < els_p; gi++) begin : entry_gen
    logic entry_en;
    assign entry_en = reset_i | (enq & (wptr_reg == ptr_w_lp'(gi)));

    bsg_fifo_1r1w_small_width_p10_els_p4_reg #(
      .width_p(width_p)
    ) entry_reg (
      .clock_i(clock_i),
      .reset_i(reset_i),
      .en_i   (entry_en),
      .data_i (data_i),
      .data_o (entry_data[gi])
    );
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (enq) wptr_reg <= wptr_reg + 1'b1;
      if (deq) rptr_reg <= rptr_reg + 1'b1;
      if (enq & ~deq)      count_reg <= count_reg + 1'b1;
      else if (deq & ~enq) count_reg <= count_reg - 1'b1;
    end
  end

  assign data_o = entry_data[rptr_reg];

endmodule

// File: tb/tb_bsg_fifo_1r1w_small_width_p10_els_p4.sv
// Directed bench: stimulus pushes expected words into a queue, a negedge monitor pops on each dequeue.
module tb_bsg_fifo_1r1w_small_width_p10_els_p4;

  logic       clock_i;
  logic       reset_i;
  logic       v_i;
  logic [9:0] data_i;
  logic       ready_o;
  logic       v_o;
  logic [9:0] data_o;
  logic       yumi_i;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q [$];

  bsg_fifo_1r1w_small_width_p10_els_p4 dut (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .v_i    (v_i),
    .data_i (data_i),
    .ready_o(ready_o),
    .v_o    (v_o),
    .data_o (data_o),
    .yumi_i (yumi_i)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one edge, then settle before the caller touches inputs.
  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Monitor: the handshake seen mid-cycle is the one the next edge will commit.
  always @(negedge clock_i) begin
    if (!reset_i && yumi_i && !v_o)
      $display("note: yumi_i asserted while v_o=0 (protocol violation, ignored)");
    if (!reset_i && yumi_i && v_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL deq_unexpected: got 0x%0h expected no delivery", data_o);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        $display("deq data=0x%03h expected=0x%03h", data_o, e);
        chk("deq_data", int'(data_o), int'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1;
    v_i     = 1'b0;
    yumi_i  = 1'b0;
    data_i  = '0;

    // Reset then idle
    step();
    settle();
    chk("ready_in_reset", int'(ready_o), 0);
    step();
    reset_i = 1'b0;
    settle();
    chk("rst_ready", int'(ready_o), 1);
    chk("rst_v", int'(v_o), 0);
    chk("rst_data", int'(data_o), 0);
    chk("rst_count", int'(dut.count_reg), 0);

    // Fill and drain
    begin
      logic [9:0] fill_vals [4];
      fill_vals = '{10'h001, 10'h002, 10'h003, 10'h3FF};
      for (int i = 0; i < 4; i++) begin
        v_i = 1'b1;
        data_i = fill_vals[i];
        exp_q.push_back(fill_vals[i]);
        $display("enq data=0x%03h", fill_vals[i]);
        step();
        if (i == 0) begin
          settle();
          chk("latency_v", int'(v_o), 1);
          chk("latency_data", int'(data_o), 'h001);
        end
      end
    end
    v_i = 1'b0;
    settle();
    chk("full_ready", int'(ready_o), 0);
    chk("full_count", int'(dut.count_reg), 4);
    chk("full_head", int'(data_o), 'h001);
    yumi_i = 1'b1;
    for (int i = 0; i < 4; i++) step();
    yumi_i = 1'b0;
    settle();
    chk("drain_v", int'(v_o), 0);
    chk("drain_ready", int'(ready_o), 1);
    chk("drain_count", int'(dut.count_reg), 0);

    // Wrap-around streaming with yumi_i following v_o
    for (int i = 0; i < 10; i++) begin
      v_i = 1'b1;
      data_i = 10'h100 + 10'(i);
      yumi_i = v_o;
      exp_q.push_back(10'h100 + 10'(i));
      $display("enq data=0x%03h", 10'h100 + 10'(i));
      step();
      settle();
      chk("stream_count", int'(dut.count_reg), 1);
      chk("stream_head", int'(data_o), 'h100 + i);
    end
    v_i = 1'b0;
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
    settle();
    chk("stream_end_count", int'(dut.count_reg), 0);

    // Full plus simultaneous enqueue/dequeue
    for (int i = 0; i < 4; i++) begin
      v_i = 1'b1;
      data_i = 10'h011 + 10'(i);
      exp_q.push_back(10'h011 + 10'(i));
      $display("enq data=0x%03h", 10'h011 + 10'(i));
      step();
    end
    data_i = 10'h2AA;
    yumi_i = 1'b1;
    settle();
    chk("full_simul_ready", int'(ready_o), 0);
    step();
    yumi_i = 1'b0;
    settle();
    chk("full_simul_count", int'(dut.count_reg), 3);
    chk("reclaim_ready", int'(ready_o), 1);
    exp_q.push_back(10'h2AA);
    $display("enq data=0x2aa");
    step();
    v_i = 1'b0;
    settle();
    chk("reclaim_count", int'(dut.count_reg), 4);
    yumi_i = 1'b1;
    for (int i = 0; i < 4; i++) step();
    yumi_i = 1'b0;
    settle();
    chk("reclaim_drain_count", int'(dut.count_reg), 0);

    // Reset mid-operation: queued words are flushed, never delivered
    for (int i = 0; i < 3; i++) begin
      v_i = 1'b1;
      data_i = 10'h0A1 + 10'(i);
      $display("enq data=0x%03h (to be flushed)", 10'h0A1 + 10'(i));
      step();
    end
    settle();
    chk("pre_flush_count", int'(dut.count_reg), 3);
    reset_i = 1'b1;
    data_i = 10'h3C3;
    yumi_i = 1'b1;
    step();
    reset_i = 1'b0;
    v_i = 1'b0;
    yumi_i = 1'b0;
    settle();
    chk("flush_count", int'(dut.count_reg), 0);
    chk("flush_v", int'(v_o), 0);
    chk("flush_data", int'(data_o), 0);
    chk("flush_ready", int'(ready_o), 1);
    chk("flush_wptr", int'(dut.wptr_reg), 0);

    // Illegal yumi while empty
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
    settle();
    chk("illegal_count", int'(dut.count_reg), 0);
    chk("illegal_rptr", int'(dut.rptr_reg), 0);
    chk("illegal_v", int'(v_o), 0);
    v_i = 1'b1;
    data_i = 10'h055;
    exp_q.push_back(10'h055);
    $display("enq data=0x055");
    step();
    v_i = 1'b0;
    settle();
    chk("post_illegal_v", int'(v_o), 1);
    chk("post_illegal_data", int'(data_o), 'h055);
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
    settle();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
